// File: rtl/sev_seg_pkg.sv
// ----------------------------------------------------------------------------
// sev_seg_pkg : shared constants, scan FSM states and hex-to-segment decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sev_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_B  = 1;
    localparam int SEG_BIT_C  = 2;
    localparam int SEG_BIT_D  = 3;
    localparam int SEG_BIT_E  = 4;
    localparam int SEG_BIT_F  = 5;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-low pattern for a common-anode digit; dp bit left dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        logic [7:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sev_seg_decoder.sv
// ----------------------------------------------------------------------------
// sev_seg_decoder : combinational 4-bit to active-low 7-segment decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sev_seg_decoder
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = seg_decode(nibble);

endmodule

`default_nettype wire

// File: rtl/sev_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sev_seg_scan_ctrl : time-multiplexed N-digit common-anode 7-segment scanner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    input  logic                  i_lz_blank,
    output logic [7:0]            o_sev_seg,
    output logic [N_DIGITS-1:0]   o_anode,
    output logic [2:0]            o_digit_idx,
    output logic                  o_frame_start,
    output logic                  o_load_ack
);

    localparam int CNT_W      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    localparam logic [CNT_W-1:0]  SLOT_END   = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_END  = CNT_W'(BLANK_LAST);
    localparam logic [2:0]        LAST_IDX   = 3'(N_DIGITS - 1);
    localparam scan_state_t       SLOT_ENTRY = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    scan_state_t           state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [2:0]            idx, idx_nxt;
    logic                  frame_boundary;

    logic [4*N_DIGITS-1:0] active_val, active_val_nxt, pend_val;
    logic [N_DIGITS-1:0]   active_dp, active_dp_nxt, pend_dp;
    logic                  pend_valid;
    logic                  ack_nxt;

    logic [N_DIGITS-1:0]   dark;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  dark_sel;
    logic [7:0]            dec_seg;
    logic [7:0]            seg_nxt;
    logic [N_DIGITS-1:0]   anode_nxt;

    // ---------------- scan sequencing ----------------
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        frame_boundary = 1'b0;

        if (!i_enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt      = SLOT_ENTRY;
                    cnt_nxt        = '0;
                    idx_nxt        = '0;
                    frame_boundary = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_END) begin
                        state_nxt = ST_SHOW;
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                end
                ST_SHOW: begin
                    if (cnt == SLOT_END) begin
                        cnt_nxt   = '0;
                        state_nxt = SLOT_ENTRY;
                        if (idx == LAST_IDX) begin
                            idx_nxt        = '0;
                            frame_boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // A strobe coinciding with the frame boundary wins over any older pending word.
    always_comb begin
        active_val_nxt = active_val;
        active_dp_nxt  = active_dp;
        ack_nxt        = 1'b0;
        if (frame_boundary) begin
            if (i_load) begin
                active_val_nxt = i_value;
                active_dp_nxt  = i_dp;
                ack_nxt        = 1'b1;
            end else if (pend_valid) begin
                active_val_nxt = pend_val;
                active_dp_nxt  = pend_dp;
                ack_nxt        = 1'b1;
            end
        end
    end

    // ---------------- leading-zero suppression ----------------
    genvar k;
    generate
        for (k = 0; k < N_DIGITS; k++) begin : g_lz
            if (k == 0) begin : g_first
                assign dark[k] = 1'b0;
            end else begin : g_rest
                assign dark[k] = i_lz_blank &&
                                 (active_val_nxt[4*N_DIGITS-1:4*k] == '0);
            end
        end
    endgenerate

    // ---------------- digit select and output shaping ----------------
    always_comb begin
        nib_sel   = '0;
        dp_sel    = 1'b0;
        dark_sel  = 1'b0;
        anode_nxt = '1;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (idx_nxt == 3'(d)) begin
                nib_sel  = active_val_nxt[4*d +: 4];
                dp_sel   = active_dp_nxt[d];
                dark_sel = dark[d];
            end
        end

        seg_nxt = SEG_BLANK;
        if ((state_nxt == ST_SHOW) && !dark_sel) begin
            seg_nxt             = dec_seg;
            seg_nxt[SEG_BIT_DP] = ~dp_sel;
            for (int d = 0; d < N_DIGITS; d++) begin
                anode_nxt[d] = (idx_nxt != 3'(d));
            end
        end
    end

    sev_seg_decoder u_decoder (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    // ---------------- registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            active_val    <= '0;
            active_dp     <= '0;
            pend_val      <= '0;
            pend_dp       <= '0;
            pend_valid    <= 1'b0;
            o_sev_seg     <= SEG_BLANK;
            o_anode       <= '1;
            o_frame_start <= 1'b0;
            o_load_ack    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            active_val    <= active_val_nxt;
            active_dp     <= active_dp_nxt;
            o_sev_seg     <= seg_nxt;
            o_anode       <= anode_nxt;
            o_frame_start <= frame_boundary;
            o_load_ack    <= ack_nxt;

            if (frame_boundary) begin
                pend_valid <= 1'b0;
            end else if (i_load) begin
                pend_val   <= i_value;
                pend_dp    <= i_dp;
                pend_valid <= 1'b1;
            end
        end
    end

    assign o_digit_idx = idx;

endmodule

`default_nettype wire
